// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command sequencer: command codes, FSM states
// and the watchdog limit.
package lcd_pkg;

    localparam logic [3:0] WRITE    = 4'd0;
    localparam logic [3:0] UP       = 4'd1;
    localparam logic [3:0] DOWN     = 4'd2;
    localparam logic [3:0] LEFT     = 4'd3;
    localparam logic [3:0] RIGHT    = 4'd4;
    localparam logic [3:0] MAX      = 4'd5;
    localparam logic [3:0] MIN      = 4'd6;
    localparam logic [3:0] AVG      = 4'd7;
    localparam logic [3:0] CCW      = 4'd8;
    localparam logic [3:0] CW       = 4'd9;
    localparam logic [3:0] MIRX     = 4'd10;
    localparam logic [3:0] MIRY     = 4'd11;
    localparam logic [3:0] CMD_LAST = 4'd11;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_RDY,
        WAIT_ACK,
        WAIT_CMPL,
        FIN
    } seq_state_e;

    localparam logic [9:0] TIMEOUT_LIMIT = 10'd1023;

endpackage

// File: rtl/lcd_script_mem.sv
// Script buffer: DEPTH x 4-bit register file, synchronous write, asynchronous read.
// Contents are deliberately not reset so a script survives a sequencer reset.
module lcd_script_mem #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [3:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [3:0]    rdata
);

    logic [3:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/lcd_cmd_seq.sv
// Replays a preloaded script of LCD commands over the controller handshake.
// Optional watchdog on the handshake waits: define LCD_SEQ_TIMEOUT_EN.
module lcd_cmd_seq
    import lcd_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [3:0]    ld_data,
    input  logic [AW:0]   len,
    input  logic          start,
    input  logic          busy,
    input  logic          done,
    output logic [3:0]    cmd,
    output logic          cmd_valid,
    output logic          seq_busy,
    output logic          seq_done,
    output logic [AW:0]   cmd_cnt,
    output logic          err
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    seq_state_e    state_q;
    logic [AW-1:0] pc_q;
    logic [AW:0]   len_q;
    logic [3:0]    cur_q;
    logic [3:0]    cmd_q;
    logic          cmd_valid_q;
    logic          seq_busy_q;
    logic          seq_done_q;
    logic [AW:0]   cmd_cnt_q;
    logic          err_q;

    logic [3:0]    rd_data;
    logic          mem_we;
    logic [AW:0]   len_d;
    logic          pc_last;
    logic          cmpl_ok;
    logic          timeout_hit;

    assign mem_we  = ld_we && (state_q == IDLE);
    assign len_d   = (len > DEPTH_L) ? DEPTH_L : len;
    assign pc_last = (((AW+1)'(pc_q)) + (AW+1)'(1)) == len_q;
    // A write ends on the controller's done; every other command ends when busy drops.
    assign cmpl_ok = (cur_q == WRITE) ? done : !busy;

    lcd_script_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (ld_addr),
        .wdata (ld_data),
        .raddr (pc_q),
        .rdata (rd_data)
    );

`ifdef LCD_SEQ_TIMEOUT_EN
    logic [9:0] wd_q;
    logic       wait_stay;

    // Counter only advances while parked in a handshake wait, so it is zero after any state change.
    assign wait_stay   = ((state_q == WAIT_ACK) && !busy) ||
                         ((state_q == WAIT_CMPL) && !cmpl_ok);
    assign timeout_hit = wait_stay && (wd_q == TIMEOUT_LIMIT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wd_q <= '0;
        end else if (wait_stay && !timeout_hit) begin
            wd_q <= wd_q + 10'd1;
        end else begin
            wd_q <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            len_q       <= '0;
            cur_q       <= '0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            seq_busy_q  <= 1'b0;
            seq_done_q  <= 1'b0;
            cmd_cnt_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            cmd_valid_q <= 1'b0;
            seq_done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        len_q      <= len_d;
                        pc_q       <= '0;
                        cmd_cnt_q  <= '0;
                        err_q      <= 1'b0;
                        seq_busy_q <= 1'b1;
                        state_q    <= (len_d == '0) ? FIN : FETCH;
                    end
                end
                FETCH: begin
                    cur_q <= rd_data;
                    if (rd_data > CMD_LAST) begin
                        err_q <= 1'b1;
                        if (pc_last) begin
                            state_q <= FIN;
                        end else begin
                            pc_q <= pc_q + AW'(1);
                        end
                    end else begin
                        state_q <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (!busy) begin
                        cmd_q       <= cur_q;
                        cmd_valid_q <= 1'b1;
                        cmd_cnt_q   <= cmd_cnt_q + (AW+1)'(1);
                        state_q     <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (busy) begin
                        state_q <= WAIT_CMPL;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        state_q <= FIN;
                    end
                end
                WAIT_CMPL: begin
                    if (cmpl_ok) begin
                        if ((cur_q == WRITE) || pc_last) begin
                            state_q <= FIN;
                        end else begin
                            pc_q    <= pc_q + AW'(1);
                            state_q <= FETCH;
                        end
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    seq_done_q <= 1'b1;
                    seq_busy_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd       = cmd_q;
    assign cmd_valid = cmd_valid_q;
    assign seq_busy  = seq_busy_q;
    assign seq_done  = seq_done_q;
    assign cmd_cnt   = cmd_cnt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Bench for lcd_cmd_seq: directed scenarios plus random scripts against a
// list-level model of which commands a script should produce.
module tb_lcd_cmd_seq;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk     = 1'b0;
    logic          reset   = 1'b0;
    logic          ld_we   = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [3:0]    ld_data = '0;
    logic [AW:0]   len     = '0;
    logic          start   = 1'b0;
    logic          busy    = 1'b0;
    logic          done    = 1'b0;
    logic [3:0]    cmd;
    logic          cmd_valid;
    logic          seq_busy;
    logic          seq_done;
    logic [AW:0]   cmd_cnt;
    logic          err;

    lcd_cmd_seq #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .len       (len),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .seq_busy  (seq_busy),
        .seq_done  (seq_done),
        .cmd_cnt   (cmd_cnt),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Controller responder and output monitor; sole owner of busy/done and the logs.
    bit   resp_en   = 1'b0;
    bit   hold_busy = 1'b0;
    int   resp_len  = 3;
    int   done_dly  = 70;
    bit   raise_pend = 1'b0;
    bit   last_write = 1'b0;
    int   busy_left = 0;
    int   done_cnt  = 0;
    int   busy_fall_cyc = 0;
    int   done_cyc  = 0;
    int   got_all[$];
    int   cv_cyc_all[$];
    int   seqdone_n = 0;
    int   seqdone_cyc = 0;
    bit   prev_cv = 1'b0;
    logic [3:0] held_cmd = '0;
    int   viol_busy = 0;
    int   viol_single = 0;
    int   viol_stable = 0;

    always @(negedge clk) begin
        if (!reset) begin
            prev_cv = 1'b0;
        end else begin
            if (cmd_valid) begin
                if (busy) viol_busy++;
                if (prev_cv) viol_single++;
                got_all.push_back(int'(cmd));
                cv_cyc_all.push_back(cyc);
                held_cmd = cmd;
            end else if (busy && (cmd != held_cmd)) begin
                viol_stable++;
            end
            prev_cv = cmd_valid;
            if (seq_done) begin
                seqdone_n++;
                seqdone_cyc = cyc;
            end
        end
        if (!resp_en) begin
            busy = 1'b0; done = 1'b0; raise_pend = 1'b0;
            busy_left = 0; done_cnt = 0; last_write = 1'b0;
        end else begin
            done = 1'b0;
            if (hold_busy) begin
                busy = 1'b1;
            end else if (raise_pend) begin
                busy = 1'b1; busy_left = resp_len; raise_pend = 1'b0;
            end else if (busy) begin
                busy_left--;
                if (busy_left <= 0) begin
                    busy = 1'b0;
                    busy_fall_cyc = cyc;
                    if (last_write) done_cnt = done_dly;
                end
            end else if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) begin
                    done = 1'b1;
                    done_cyc = cyc;
                end
            end
            if (cmd_valid) begin
                raise_pend = 1'b1;
                last_write = (cmd == 4'd0);
            end
        end
    end

    // Reference model: the list of commands a script produces and whether it flags an error.
    logic [3:0] model_mem [DEPTH];
    int exp_q[$];
    bit exp_err;
    int run_base;
    int done_base;
    int run_s;

    task automatic model(input int l);
        int n;
        n = (l > DEPTH) ? DEPTH : l;
        exp_q.delete();
        exp_err = 1'b0;
        for (int i = 0; i < n; i++) begin
            int c;
            c = int'(model_mem[i]);
            if (c > 11) begin
                exp_err = 1'b1;
                continue;
            end
            exp_q.push_back(c);
            if (c == 0) break;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input int a, input int d);
        @(negedge clk);
        ld_we = 1'b1; ld_addr = AW'(a); ld_data = 4'(d);
        @(negedge clk);
        ld_we = 1'b0;
        model_mem[a] = 4'(d);
    endtask

    task automatic start_run(input int l);
        model(l);
        @(negedge clk);
        len = (AW+1)'(l);
        start = 1'b1;
        run_s = cyc;
        run_base = got_all.size();
        done_base = seqdone_n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_run(input string tag);
        int t;
        int n_got;
        t = 0;
        while ((seqdone_n == done_base) && (t < 6000)) begin
            @(negedge clk);
            t++;
        end
        check({tag, " seq_done_seen"}, int'(seqdone_n != done_base), 1);
        tick(3);
        check({tag, " seq_done_pulses"}, seqdone_n - done_base, 1);
        check({tag, " seq_done_low"}, int'(seq_done), 0);
        n_got = got_all.size() - run_base;
        check({tag, " n_cmds"}, n_got, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s cmd[%0d]", tag, i),
                  (i < n_got) ? got_all[run_base + i] : -1, exp_q[i]);
        end
        check({tag, " cmd_cnt"}, int'(cmd_cnt), exp_q.size());
        check({tag, " err"}, int'(err), int'(exp_err));
        check({tag, " seq_busy"}, int'(seq_busy), 0);
        check({tag, " viol_cv_busy"}, viol_busy, 0);
        check({tag, " viol_cv_single"}, viol_single, 0);
        check({tag, " viol_cmd_stable"}, viol_stable, 0);
        $display("[TB] %s: len=%0d got %0d cmds, cmd_cnt=%0d err=%0d", tag,
                 int'(len), n_got, int'(cmd_cnt), int'(err));
    endtask

    task automatic check_reset(input string tag);
        check({tag, " cmd"}, int'(cmd), 0);
        check({tag, " cmd_valid"}, int'(cmd_valid), 0);
        check({tag, " seq_busy"}, int'(seq_busy), 0);
        check({tag, " seq_done"}, int'(seq_done), 0);
        check({tag, " cmd_cnt"}, int'(cmd_cnt), 0);
        check({tag, " err"}, int'(err), 0);
    endtask

    function automatic int first_cv_delta(input int ref_cyc);
        if (got_all.size() > run_base) return cv_cyc_all[run_base] - ref_cyc;
        return -1000;
    endfunction

    initial begin
        #1_500_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        // Reset state
        reset = 1'b0;
        tick(4);
        check_reset("reset");

        // Controller holds busy after reset; first issue must wait for it
        hold_busy = 1'b1;
        resp_en = 1'b1;
        resp_len = 3;
        done_dly = 70;
        tick(1);
        reset = 1'b1;
        load(0, 1); load(1, 3); load(2, 5); load(3, 0);
        start_run(4);
        tick(130);
        check("hold no_cv", got_all.size() - run_base, 0);
        check("hold seq_busy", int'(seq_busy), 1);
        hold_busy = 1'b0;
        t = 0;
        while ((got_all.size() == run_base) && (t < 50)) begin
            @(posedge clk);
            t++;
        end
        check("hold rdy_latency", first_cv_delta(busy_fall_cyc), 1);
        finish_run("script_1350");
        check("script_1350 done_to_seq_done", seqdone_cyc - done_cyc, 2);

        // Invalid code is skipped and flagged; latency from start with busy low
        load(0, 2); load(1, 14); load(2, 4);
        start_run(3);
        finish_run("skip_invalid");
        check("skip_invalid start_latency", first_cv_delta(run_s), 3);

        // Empty script
        start_run(0);
        finish_run("len0");
        check("len0 start_to_seq_done", seqdone_cyc - run_s, 2);

        // Write ends the script; start and load during the run are ignored
        load(0, 0); load(1, 1); load(2, 2);
        start_run(3);
        tick(8);
        @(negedge clk);
        start = 1'b1; ld_we = 1'b1; ld_addr = AW'(1); ld_data = 4'd7;
        @(negedge clk);
        start = 1'b0; ld_we = 1'b0;
        finish_run("write_stop");
        check("write_stop done_to_seq_done", seqdone_cyc - done_cyc, 2);
        load(0, 1);
        start_run(3);
        finish_run("buffer_kept");

        // Reset in the middle of a command, then replay
        load(0, 3); load(1, 4); load(2, 5); load(3, 6);
        resp_len = 6;
        start_run(4);
        t = 0;
        while ((got_all.size() - run_base < 2) && (t < 200)) begin
            @(negedge clk);
            t++;
        end
        tick(3);
        check("midrst pre_busy", int'(seq_busy), 1);
        @(negedge clk);
        resp_en = 1'b0;
        reset = 1'b0;
        tick(3);
        check_reset("midrst");
        @(negedge clk);
        reset = 1'b1;
        resp_en = 1'b1;
        tick(2);
        start_run(4);
        finish_run("midrst_replay");

        // Random scripts
        for (int k = 0; k < 8; k++) begin
            int l;
            resp_len = $urandom_range(1, 5);
            done_dly = $urandom_range(1, 12);
            for (int a = 0; a < DEPTH; a++) begin
                int d;
                d = $urandom_range(0, 15);
                if ((d == 0) && ($urandom_range(0, 3) != 0)) d = $urandom_range(1, 11);
                load(a, d);
            end
            l = $urandom_range(0, 40);
            start_run(l);
            finish_run($sformatf("rand%0d", k));
        end

`ifdef LCD_SEQ_TIMEOUT_EN
        // Busy stuck high after issue trips the watchdog
        resp_len = 3;
        load(0, 1);
        start_run(1);
        t = 0;
        while ((got_all.size() == run_base) && (t < 50)) begin
            @(negedge clk);
            t++;
        end
        hold_busy = 1'b1;
        t = 0;
        while ((seqdone_n == done_base) && (t < 3000)) begin
            @(negedge clk);
            t++;
        end
        check("timeout seq_done_seen", int'(seqdone_n != done_base), 1);
        check("timeout err", int'(err), 1);
        t = seqdone_cyc - ((got_all.size() > run_base) ? cv_cyc_all[run_base] : 0);
        check("timeout window", int'((t >= 1024) && (t <= 1030)), 1);
        $display("[TB] timeout: seq_done %0d cycles after cmd_valid", t);
        hold_busy = 1'b0;
        resp_en = 1'b0;
        tick(2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
